jpeg_rle_decoder: RTL and testbench

- Decoder-side counterpart to the JPEG entropy/run-length encoder datapath.
- Consumes per-block Huffman-decoded symbol tokens (run, size, amplitude bits) and expands them into 64 signed coefficients per 8x8 block, in zigzag order, one coefficient per cycle.
- Reconstructs the differential DC value and expands EOB and ZRL zero runs.
- Sits between the Huffman symbol decoder and the dequantiser/de-zigzag buffer, with valid/ready on both sides.

---
 rtl/jpeg_dec_pkg.sv | 34 +++
 rtl/jpeg_amp_extend.sv | 15 +
 rtl/jpeg_rle_decoder.sv | 139 +++++++++++++
 tb/tb_jpeg_rle_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_dec_pkg.sv
// rtl/jpeg_dec_pkg.sv - shared constants, types and amplitude extension for the JPEG RLE decoder
package jpeg_dec_pkg;

    localparam int COEF_WIDTH = 12;
    localparam int AMP_WIDTH  = 11;
    localparam int BLK_LAST   = 63;

    localparam logic [2:0] S_DC   = 3'd0;
    localparam logic [2:0] S_AC   = 3'd1;
    localparam logic [2:0] S_ZERO = 3'd2;
    localparam logic [2:0] S_VAL  = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;

    localparam logic [3:0] EOB_RUN     = 4'd0;
    localparam logic [3:0] EOB_SIZE    = 4'd0;
    localparam logic [3:0] ZRL_RUN     = 4'd15;
    localparam logic [3:0] ZRL_SIZE    = 4'd0;
    localparam logic [3:0] DC_SIZE_MAX = 4'd11;
    localparam logic [3:0] AC_SIZE_MAX = 4'd10;

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    // A clear top amplitude bit marks a negative value stored as its ones' complement.
    function automatic coef_t amp_extend(input logic [3:0] size, input logic [AMP_WIDTH-1:0] amp);
        logic [COEF_WIDTH-1:0] mask;
        logic [COEF_WIDTH-1:0] bits;
        if (size == 4'd0 || size > 4'(AMP_WIDTH)) return '0;
        mask = (COEF_WIDTH'(1) << size) - COEF_WIDTH'(1);
        bits = COEF_WIDTH'(amp) & mask;
        if (bits[size - 4'd1]) return coef_t'(bits);
        return coef_t'(bits - mask);
    endfunction

endpackage

// File: rtl/jpeg_amp_extend.sv
// rtl/jpeg_amp_extend.sv - combinational size/amplitude to signed coefficient conversion
module jpeg_amp_extend
    import jpeg_dec_pkg::*;
#(
    parameter int COEF_W = COEF_WIDTH,
    parameter int AMP_W  = AMP_WIDTH
) (
    input  logic [3:0]              i_size,
    input  logic [AMP_W-1:0]        i_amp,
    output logic signed [COEF_W-1:0] o_value
);

    assign o_value = COEF_W'(amp_extend(i_size, AMP_WIDTH'(i_amp)));

endmodule

// File: rtl/jpeg_rle_decoder.sv
// rtl/jpeg_rle_decoder.sv - expands Huffman symbol tokens into 64 zigzag coefficients per block
module jpeg_rle_decoder
    import jpeg_dec_pkg::*;
#(
    parameter int COEF_W = COEF_WIDTH,
    parameter int AMP_W  = AMP_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_run,
    input  logic [3:0]               in_size,
    input  logic [AMP_W-1:0]         in_amp,
    input  logic                     clear_pred,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_coef,
    output logic [5:0]               out_idx,
    output logic                     out_last,
    output logic                     err
);

    logic [2:0]               r_state;
    logic signed [COEF_W-1:0] r_pred;
    logic signed [COEF_W-1:0] r_coef;
    logic signed [COEF_W-1:0] r_val;
    logic [5:0]               r_idx;
    logic [3:0]               r_zcnt;
    logic                     r_have_val;
    logic                     r_err;

    logic signed [COEF_W-1:0] w_ext;
    logic signed [COEF_W-1:0] w_amp_val;
    logic signed [COEF_W-1:0] w_dc_val;
    logic                     w_size_bad;
    logic                     w_is_eob;
    logic                     w_is_zrl;
    logic [6:0]               w_base;
    logic [6:0]               w_val_pos;

    jpeg_amp_extend #(
        .COEF_W (COEF_W),
        .AMP_W  (AMP_W)
    ) u_amp_extend (
        .i_size  (in_size),
        .i_amp   (in_amp),
        .o_value (w_ext)
    );

    assign in_ready   = (r_state == S_DC) || (r_state == S_AC);
    assign out_valid  = (r_state == S_ZERO) || (r_state == S_VAL) || (r_state == S_FILL);
    assign out_coef   = r_coef;
    assign out_idx    = r_idx;
    assign out_last   = (r_idx == 6'(BLK_LAST));
    assign err        = r_err;

    assign w_size_bad = (r_state == S_DC) ? (in_size > DC_SIZE_MAX) : (in_size > AC_SIZE_MAX);
    assign w_amp_val  = w_size_bad ? '0 : w_ext;
    assign w_dc_val   = w_amp_val + (clear_pred ? '0 : r_pred);
    assign w_is_eob   = (in_run == EOB_RUN) && (in_size == EOB_SIZE);
    assign w_is_zrl   = (in_run == ZRL_RUN) && (in_size == ZRL_SIZE);
    // Index of the first coefficient a new AC token emits, and of its last (value or 16th ZRL zero).
    assign w_base     = {1'b0, r_idx} + 7'd1;
    assign w_val_pos  = w_base + {3'b000, in_run};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_DC;
            r_pred     <= '0;
            r_coef     <= '0;
            r_val      <= '0;
            r_idx      <= '0;
            r_zcnt     <= '0;
            r_have_val <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (clear_pred) r_pred <= '0;
            case (r_state)
                S_DC: begin
                    if (in_valid) begin
                        r_pred  <= w_dc_val;
                        r_coef  <= w_dc_val;
                        r_idx   <= '0;
                        r_state <= S_VAL;
                        if (w_size_bad) r_err <= 1'b1;
                    end
                end
                S_AC: begin
                    if (in_valid) begin
                        if (w_size_bad) r_err <= 1'b1;
                        r_idx  <= w_base[5:0];
                        r_coef <= '0;
                        if (w_is_eob) begin
                            r_state <= S_FILL;
                        end else if (w_val_pos > 7'(BLK_LAST)) begin
                            r_err   <= 1'b1;
                            r_state <= S_FILL;
                        end else if (in_run == 4'd0) begin
                            r_coef  <= w_amp_val;
                            r_state <= S_VAL;
                        end else begin
                            r_zcnt     <= w_is_zrl ? in_run : in_run - 4'd1;
                            r_val      <= w_amp_val;
                            r_have_val <= !w_is_zrl;
                            r_state    <= S_ZERO;
                        end
                    end
                end
                S_ZERO, S_VAL, S_FILL: begin
                    if (out_ready) begin
                        if (out_last) begin
                            r_state <= S_DC;
                            r_idx   <= '0;
                            r_coef  <= '0;
                        end else if (r_state == S_ZERO) begin
                            if (r_zcnt != 4'd0) begin
                                r_idx  <= r_idx + 6'd1;
                                r_zcnt <= r_zcnt - 4'd1;
                            end else if (r_have_val) begin
                                r_idx   <= r_idx + 6'd1;
                                r_coef  <= r_val;
                                r_state <= S_VAL;
                            end else begin
                                r_state <= S_AC;
                            end
                        end else if (r_state == S_VAL) begin
                            r_state <= S_AC;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                default: r_state <= S_DC;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_rle_decoder.sv
// tb/tb_jpeg_rle_decoder.sv - randomized self-checking bench with a token-level reference model
module tb_jpeg_rle_decoder;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [3:0]         in_run = '0;
    logic [3:0]         in_size = '0;
    logic [10:0]        in_amp = '0;
    logic               clr_tok = 1'b0;
    logic               clr_rand = 1'b0;
    logic               clear_pred;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [11:0] out_coef;
    logic [5:0]         out_idx;
    logic               out_last;
    logic               err;

    assign clear_pred = clr_tok | clr_rand;

    jpeg_rle_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_run     (in_run),
        .in_size    (in_size),
        .in_amp     (in_amp),
        .clear_pred (clear_pred),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_coef   (out_coef),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct { int coef; int idx; bit last; } exp_t;
    typedef struct { bit [3:0] run; bit [3:0] size; bit [10:0] amp; bit clr; } tok_t;

    exp_t q[$];
    exp_t obs[$];
    int   checks = 0;
    int   errors = 0;
    int   pred_m = 0;
    int   pos_m  = 0;
    bit   err_m  = 1'b0;
    bit   rnd_ready = 1'b1;
    bit   rnd_clr   = 1'b0;

    function void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function int ext_f(int size, int amp);
        int a;
        if (size == 0) return 0;
        a = amp % (2 ** size);
        if (a >= 2 ** (size - 1)) return a;
        return a - (2 ** size - 1);
    endfunction

    function int wrap12(int v);
        int w;
        w = ((v % 4096) + 4096) % 4096;
        return (w >= 2048) ? w - 4096 : w;
    endfunction

    function void push(int c, int i);
        q.push_back('{c, i, (i == 63)});
    endfunction

    function void fill_rest();
        for (int i = pos_m; i < 64; i++) push(0, i);
        pos_m = 0;
    endfunction

    function void apply(int run, int size, int amp);
        int e;
        if (pos_m == 0) begin
            e = (size > 11) ? 0 : ext_f(size, amp);
            if (size > 11) err_m = 1'b1;
            pred_m = wrap12(e + pred_m);
            push(pred_m, 0);
            pos_m = 1;
        end else begin
            e = (size > 10) ? 0 : ext_f(size, amp);
            if (size > 10) err_m = 1'b1;
            if (run == 0 && size == 0) begin
                fill_rest();
            end else if (run == 15 && size == 0) begin
                if (pos_m + 16 > 64) begin
                    err_m = 1'b1;
                    fill_rest();
                end else begin
                    for (int i = 0; i < 16; i++) push(0, pos_m + i);
                    pos_m += 16;
                    if (pos_m == 64) pos_m = 0;
                end
            end else if (pos_m + run > 63) begin
                err_m = 1'b1;
                fill_rest();
            end else begin
                for (int i = 0; i < run; i++) push(0, pos_m + i);
                push(e, pos_m + run);
                pos_m += run + 1;
                if (pos_m == 64) pos_m = 0;
            end
        end
    endfunction

    // Handshakes are decided on the sampled values and take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            pred_m = 0;
            pos_m  = 0;
            err_m  = 1'b0;
        end else begin
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            chk("in_ready", int'(in_ready), int'(q.size() == 0));
            chk("err", int'(err), int'(err_m));
            if (out_valid && q.size() != 0) begin
                chk("coef", int'(out_coef), q[0].coef);
                chk("idx", int'(out_idx), q[0].idx);
                chk("last", int'(out_last), int'(q[0].last));
                if (out_ready) begin
                    obs.push_back('{int'(out_coef), int'(out_idx), out_last});
                    void'(q.pop_front());
                end
            end
            if (clear_pred) pred_m = 0;
            if (in_valid && in_ready) apply(int'(in_run), int'(in_size), int'(in_amp));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            clr_rand  = rnd_clr && ($urandom_range(0, 24) == 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic tok_t mk(int r, int s, int a, bit c = 1'b0);
        tok_t t;
        t.run  = 4'(r);
        t.size = 4'(s);
        t.amp  = 11'(a);
        t.clr  = c;
        return t;
    endfunction

    task automatic send(tok_t t);
        bit done;
        done = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        if (t.clr) begin
            clr_tok = 1'b1;
            @(posedge clk);
            #1;
            clr_tok = 1'b0;
        end
        in_valid = 1'b1;
        in_run   = t.run;
        in_size  = t.size;
        in_amp   = t.amp;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("send_timeout", int'(done), 1);
    endtask

    task automatic send_all(tok_t ts[$]);
        foreach (ts[i]) send(ts[i]);
    endtask

    task automatic drain();
        for (int c = 0; c < 2000 && q.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        tok_t ts[$];
        int   n0;
        int   p;
        int   r;
        int   sz;
        int   maxr;
        bit   blk_done;
        bit   hit;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_err", int'(err), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_coef", int'(out_coef), 0);
        chk("rst_out_last", int'(out_last), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rnd_ready = 1'b1;
        ts = '{mk(0, 3, 2), mk(2, 2, 3), mk(0, 0, 0),
               mk(0, 1, 1), mk(0, 0, 0),
               mk(0, 1, 0, 1'b1), mk(0, 0, 0),
               mk(0, 0, 0), mk(15, 0, 0), mk(15, 0, 0), mk(15, 0, 0), mk(14, 1, 1)};
        send_all(ts);
        drain();
        chk("dir_size", obs.size(), 256);
        if (obs.size() >= 256) begin
            chk("b1_idx0", obs[0].coef, -5);
            chk("b1_idx1", obs[1].coef, 0);
            chk("b1_idx3", obs[3].coef, 3);
            chk("b1_idx3_pos", obs[3].idx, 3);
            chk("b1_last62", int'(obs[62].last), 0);
            chk("b1_last63", int'(obs[63].last), 1);
            chk("b2_idx0", obs[64].coef, -4);
            chk("b3_idx0", obs[128].coef, -1);
            chk("b4_idx0", obs[192].coef, -1);
            chk("b4_idx62", obs[254].coef, 0);
            chk("b4_idx63", obs[255].coef, 1);
            chk("b4_last", int'(obs[255].last), 1);
        end

        rnd_clr = 1'b1;
        for (int b = 0; b < 40; b++) begin
            rnd_ready = (b % 3 != 0);
            ts.delete();
            sz = $urandom_range(0, 11);
            ts.push_back(mk(0, sz, int'($urandom % (2 ** sz))));
            p = 1;
            blk_done = 1'b0;
            while (!blk_done) begin
                r = $urandom_range(0, 99);
                if (r < 8) begin
                    ts.push_back(mk(0, 0, 0));
                    blk_done = 1'b1;
                end else if (r < 15 && p + 16 <= 64) begin
                    ts.push_back(mk(15, 0, 0));
                    p += 16;
                    if (p == 64) blk_done = 1'b1;
                end else begin
                    maxr = (63 - p > 15) ? 15 : 63 - p;
                    sz = $urandom_range(1, 10);
                    ts.push_back(mk($urandom_range(0, maxr), sz, int'($urandom % (2 ** sz))));
                    p += int'(ts[$].run) + 1;
                    if (p == 64) blk_done = 1'b1;
                end
            end
            send_all(ts);
        end
        rnd_clr = 1'b0;
        drain();

        rnd_ready = 1'b1;
        ts = '{mk(0, 0, 0), mk(15, 0, 0), mk(15, 0, 0), mk(15, 0, 0), mk(15, 1, 1)};
        send_all(ts);
        drain();
        chk("ovf_err", int'(err), 1);
        n0 = obs.size();
        chk("ovf_first_idx", obs[n0 - 15].idx, 49);
        chk("ovf_last_idx", obs[n0 - 1].idx, 63);
        chk("ovf_last_coef", obs[n0 - 1].coef, 0);
        chk("ovf_last_flag", int'(obs[n0 - 1].last), 1);

        ts = '{mk(0, 0, 0), mk(0, 0, 0)};
        send_all(ts);
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk);
            if (out_valid && out_idx == 6'd20) hit = 1'b1;
        end
        chk("rst_hit_idx20", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = obs.size();
        ts = '{mk(0, 2, 2), mk(0, 0, 0)};
        send_all(ts);
        drain();
        chk("post_rst_dc", obs[n0].coef, 2);
        chk("post_rst_idx", obs[n0].idx, 0);

        n0 = obs.size();
        ts = '{mk(0, 13, 5), mk(0, 11, 3), mk(0, 0, 0)};
        send_all(ts);
        drain();
        chk("illegal_err", int'(err), 1);
        chk("illegal_dc", obs[n0].coef, 2);
        chk("illegal_ac", obs[n0 + 1].coef, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
